// File: rtl/predecode_queue_if.sv
// Fetch-side push and dispatch-side pop bundle for the opcode prefetch queue.
// Head outputs use inverted polarity to match the decode logic they feed.
interface predecode_queue_if #(
  parameter int TAG_W = 16,
  parameter int CNT_W = 3
);
  logic             FLUSH;
  logic             WR_VALID;
  logic             WR_READY;
  logic [7:0]       WR_DATA;
  logic [TAG_W-1:0] WR_TAG;
  logic             Z_IR;
  logic             RD_VALID;
  logic             RD_READY;
  logic [7:0]       n_PD;
  logic [TAG_W-1:0] RD_TAG;
  logic             n_IMPLIED;
  logic             n_TWOCYCLE;
  logic [CNT_W-1:0] COUNT;

  modport master (
    output FLUSH, WR_VALID, WR_DATA, WR_TAG, Z_IR, RD_READY,
    input  WR_READY, RD_VALID, n_PD, RD_TAG,
    input  n_IMPLIED, n_TWOCYCLE, COUNT
  );

  modport slave (
    input  FLUSH, WR_VALID, WR_DATA, WR_TAG, Z_IR, RD_READY,
    output WR_READY, RD_VALID, n_PD, RD_TAG,
    output n_IMPLIED, n_TWOCYCLE, COUNT
  );
endinterface

// File: rtl/predecode_queue.sv
// Opcode prefetch FIFO; each byte is classified on entry so dispatch
// receives opcode, PC tag and IMPLIED/TWOCYCLE flags together.
module predecode_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic              CLK,
  input logic              RES,
  predecode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0]       pd;
    logic             imp;
    logic             two;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t             mem_q [DEPTH];
  ent_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       wr_ready, rd_valid;
  logic       push, pop;
  logic [7:0] pd_in;
  logic       t1, t2, t3, imp_in;
  ent_t       ent_in;
  ent_t       head;

  assign wr_ready = cnt_q != CNT_W'(DEPTH);
  assign rd_valid = cnt_q != '0;
  assign push     = bus.WR_VALID & wr_ready;
  assign pop      = rd_valid & bus.RD_READY;

  always_comb begin
    pd_in  = bus.Z_IR ? 8'h00 : bus.WR_DATA;
    imp_in = ~pd_in[0] & ~pd_in[2] & pd_in[3];
    t1     = ~pd_in[1] & ~pd_in[4] & ~pd_in[7];
    t2     = pd_in[0] & ~pd_in[2] & pd_in[3] & ~pd_in[4];
    t3     = ~pd_in[0] & ~pd_in[2] & ~pd_in[3]
           & ~pd_in[4] & pd_in[7];
    ent_in.pd  = pd_in;
    ent_in.imp = imp_in;
    ent_in.two = (imp_in & ~t1) | t2 | t3;
    ent_in.tag = bus.WR_TAG;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ent_in;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.WR_READY   = wr_ready;
  assign bus.RD_VALID   = rd_valid;
  assign bus.COUNT      = cnt_q;
  assign bus.n_PD       = rd_valid ? ~head.pd : 8'hFF;
  assign bus.RD_TAG     = rd_valid ? head.tag : '0;
  assign bus.n_IMPLIED  = rd_valid ? ~head.imp : 1'b1;
  assign bus.n_TWOCYCLE = rd_valid ? ~head.two : 1'b1;
endmodule

// File: tb/tb_predecode_queue.sv
// Scoreboard bench for predecode_queue: directed pushes enqueue
// hand-computed entries, a negedge monitor checks each pop.
module tb_predecode_queue;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  predecode_queue_if #(.TAG_W(16), .CNT_W(3)) bus ();

  predecode_queue #(.DEPTH(4), .TAG_W(16)) dut (
    .CLK (clk),
    .RES (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  pd;
    logic        imp;
    logic        two;
    logic [15:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.RD_VALID && bus.RD_READY && !bus.FLUSH) begin
      if (sb.size() == 0) begin
        chk("pop_underflow", 32'd1, 32'd0);
      end else begin
        exp_t       e;
        logic [7:0] npd;
        e   = sb.pop_front();
        npd = ~e.pd;
        chk("n_pd", 32'(bus.n_PD), 32'(npd));
        chk("rd_tag", 32'(bus.RD_TAG), 32'(e.tag));
        chk("n_implied", 32'(bus.n_IMPLIED), 32'(!e.imp));
        chk("n_twocycle", 32'(bus.n_TWOCYCLE), 32'(!e.two));
      end
    end
  end

  task automatic idle();
    bus.WR_VALID = 1'b0;
    bus.RD_READY = 1'b0;
    bus.FLUSH    = 1'b0;
    bus.Z_IR     = 1'b0;
  endtask

  task automatic cyc(input logic wv, input logic [7:0] d,
                     input logic [15:0] t, input logic z,
                     input logic rr, input logic fl,
                     input logic acc, input logic [7:0] epd,
                     input logic ei, input logic e2);
    bus.WR_VALID = wv;
    bus.WR_DATA  = d;
    bus.WR_TAG   = t;
    bus.Z_IR     = z;
    bus.RD_READY = rr;
    bus.FLUSH    = fl;
    @(negedge clk);
    if (wv) begin
      chk("wr_ready", 32'(bus.WR_READY), 32'(acc));
      if (acc && !fl) sb.push_back('{epd, ei, e2, t});
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [7:0] d, input logic [15:0] t,
                      input logic acc, input logic ei,
                      input logic e2);
    cyc(1'b1, d, t, 1'b0, 1'b0, 1'b0, acc, d, ei, e2);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0,
        8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_count"}, 32'(bus.COUNT), 32'd0);
    chk({nm, "_rd_valid"}, 32'(bus.RD_VALID), 32'd0);
    chk({nm, "_n_pd"}, 32'(bus.n_PD), 32'hFF);
    chk({nm, "_n_imp"}, 32'(bus.n_IMPLIED), 32'd1);
    chk({nm, "_n_two"}, 32'(bus.n_TWOCYCLE), 32'd1);
    chk({nm, "_wr_ready"}, 32'(bus.WR_READY), 32'd1);
    chk({nm, "_rd_tag"}, 32'(bus.RD_TAG), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    bus.WR_DATA = 8'h00;
    bus.WR_TAG  = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_empty("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // classification; no fall-through while empty
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 8'hEA;
    bus.WR_TAG   = 16'h0010;
    @(negedge clk);
    chk("nofall_rd_valid", 32'(bus.RD_VALID), 32'd0);
    chk("nofall_n_pd", 32'(bus.n_PD), 32'hFF);
    chk("wr_ready", 32'(bus.WR_READY), 32'd1);
    sb.push_back('{8'hEA, 1'b1, 1'b1, 16'h0010});
    @(posedge clk);
    #1;
    idle();
    chk("lat_rd_valid", 32'(bus.RD_VALID), 32'd1);
    pop();
    push(8'hA9, 16'h0011, 1'b1, 1'b0, 1'b1); pop();
    push(8'hA2, 16'h0012, 1'b1, 1'b0, 1'b1); pop();
    push(8'h48, 16'h0013, 1'b1, 1'b1, 1'b0); pop();
    push(8'h00, 16'h0014, 1'b1, 1'b0, 1'b0); pop();

    // Z_IR forces BRK
    cyc(1'b1, 8'hA9, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1,
        8'h00, 1'b0, 1'b0);
    chk("zir_rd_valid", 32'(bus.RD_VALID), 32'd1);
    chk("zir_n_pd", 32'(bus.n_PD), 32'hFF);
    chk("zir_tag", 32'(bus.RD_TAG), 32'h1234);
    chk("zir_n_two", 32'(bus.n_TWOCYCLE), 32'd1);
    pop();

    // fill, drop on full, wrap
    for (int i = 0; i < 4; i++)
      push(8'h10 + 8'(i), 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b0);
    chk("full_count", 32'(bus.COUNT), 32'd4);
    chk("full_wr_ready", 32'(bus.WR_READY), 32'd0);
    push(8'h14, 16'h0104, 1'b0, 1'b0, 1'b0);
    chk("drop_count", 32'(bus.COUNT), 32'd4);
    pop(); pop();
    push(8'h20, 16'h0120, 1'b1, 1'b0, 1'b0);
    push(8'h21, 16'h0121, 1'b1, 1'b0, 1'b0);
    repeat (4) pop();
    chk("wrap_count", 32'(bus.COUNT), 32'd0);

    // simultaneous push and pop
    push(8'h30, 16'h0130, 1'b1, 1'b0, 1'b0);
    push(8'h31, 16'h0131, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 16'h0132, 1'b0, 1'b1, 1'b0, 1'b1,
        8'h32, 1'b0, 1'b0);
    chk("pp_mid_count", 32'(bus.COUNT), 32'd2);
    push(8'h33, 16'h0133, 1'b1, 1'b0, 1'b0);
    push(8'h34, 16'h0134, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h35, 16'h0135, 1'b0, 1'b1, 1'b0, 1'b0,
        8'h35, 1'b0, 1'b0);
    chk("pp_full_count", 32'(bus.COUNT), 32'd3);

    // flush beats push and pop
    cyc(1'b1, 8'h36, 16'h0136, 1'b0, 1'b1, 1'b1, 1'b1,
        8'h36, 1'b0, 1'b0);
    sb.delete();
    chk_empty("flush");

    // async reset mid-burst
    push(8'h40, 16'h0140, 1'b1, 1'b0, 1'b0);
    push(8'h41, 16'h0141, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.COUNT), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk_empty("async_rst");
    sb.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(8'h48, 16'h4848, 1'b1, 1'b1, 1'b0);
    pop();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
